mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between instruction fetch (IF) and the MEM stage.
//  The MEM stage is driven by the EX_MEM outputs: mem_read_n2, mem_write_n2, alu_out_n and rs2_data_n.
//  Sequences every access, arbitrates between the two requesters round-robin, and returns read data.
//  Drives stall_if and stall_mem so the pipeline holds while its access is outstanding.
// PARAMETERS
//  ADDR_W   32  memory address width
//  DATA_W   32  memory data width
//  MEM_LAT  2   memory read latency in cycles (>=1); see memory contract below
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  reset      in   1       asynchronous, active-low (0 = reset)
//  if_req     in   1       fetch request; held with if_addr until if_valid
//  if_addr    in   ADDR_W  fetch address (PC)
//  if_rdata   out  DATA_W  fetched instruction; updated at capture, held otherwise
//  if_valid   out  1       one-cycle pulse: if_rdata holds the completed fetch
//  dm_read    in   1       data load request (mem_read_n2)
//  dm_write   in   1       data store request (mem_write_n2)
//  dm_addr    in   ADDR_W  data address (alu_out_n)
//  dm_wdata   in   DATA_W  store data (rs2_data_n)
//  dm_rdata   out  DATA_W  load data; updated at capture, held otherwise
//  dm_valid   out  1       one-cycle pulse: data access complete
//  stall_if   out  1       if_req & ~if_valid (combinational)
//  stall_mem  out  1       (dm_read|dm_write) & ~dm_valid (combinational)
//  mem_en     out  1       memory command strobe, exactly one cycle per access
//  mem_we     out  1       1 = write, valid while mem_en is high
//  mem_addr   out  ADDR_W  command address, registered
//  mem_wdata  out  DATA_W  command write data, registered
//  mem_rdata  in   DATA_W  memory read data
// BEHAVIOUR
//  Reset values: state=IDLE, cnt=0, last_grant=IF, and every registered output = 0.
//  In-flight reads are discarded on reset, and no valid pulse follows the reset release.
//  FSM states: IDLE, IF_WAIT, DM_WAIT. All outputs except the two stalls are registered.
//  Grant is evaluated at each edge while in IDLE:
//   - Only one requester active: that requester wins.
//   - Both active: the requester opposite to last_grant wins (round-robin).
//   - last_grant resets to IF, so DM wins the first tie.
//   - No requester active: stay in IDLE.
//  Issue at grant edge E0: mem_en=1 for the cycle after E0; mem_addr/mem_we/mem_wdata latched.
//   Move to X_WAIT and load cnt=MEM_LAT. The winner updates last_grant.
//  Memory contract: memory samples the command at E1.
//   mem_rdata is valid in the cycle following edge E(MEM_LAT).
//  Read in X_WAIT, at each edge:
//   - cnt!=0: decrement cnt.
//   - cnt==0 (edge E(MEM_LAT+1)): capture mem_rdata into x_rdata, pulse x_valid for one cycle,
//     return to IDLE.
//  Read timing: x_valid is high in the cycle after E(MEM_LAT+1); occupancy is MEM_LAT+2 cycles.
//  Write: completes at E1. dm_valid pulses in the cycle after E1, then IDLE. dm_rdata is unchanged.
//  dm_read and dm_write both high: treated as a write.
//  The valid cycle is always an IDLE cycle. A request seen at the edge ending that cycle is a new
//   access (back-to-back with no gap). There is no issue on the completion edge itself.
//  Request dropped mid-transaction: the access still completes and valid still pulses.
//   The requester ignores that pulse.
//  Address or data changes mid-transaction have no effect; command fields are latched at issue.
//  cnt width is clog2(MEM_LAT+1). cnt never wraps: it is decremented only while nonzero.
// TESTING
//  1 Hold reset=0 for 2 cycles with random inputs -> all registered outputs 0; stalls follow
//    their formulas.
//  2 MEM_LAT=2; if_req=1, if_addr=0x40 seen at E0; memory model returns 0x002082B3 ->
//    mem_en=1,mem_we=0,mem_addr=0x40 in one cycle only; if_valid high after E3 with
//    if_rdata=0x002082B3; stall_if=1 until then.
//  3 dm_write=1, dm_addr=0xD8, dm_wdata=55 -> mem_we=1, mem_wdata=55 for one cycle;
//    dm_valid after E1; dm_rdata unchanged.
//  4 Both requesting continuously from reset (DM addr 0x70, IF addr 0x0) -> grant order
//    DM, IF, DM, IF; each mem_en carries the correct address; no lost or duplicated valid.
//  5 Load 0x70 in flight; assert reset=0 mid-DM_WAIT -> outputs clear at once; after release
//    no dm_valid appears without a new request.
//  6 dm_read=1 and dm_write=1 together -> a single write command (mem_we=1); dm_valid
//    after E1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port synchronous memory shared between
// instruction fetch and the MEM stage, with round-robin arbitration.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    IF_WAIT,
    DM_WAIT
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_dm;
  logic             r_wr;

  logic w_dm_req;
  logic w_grant_dm;
  logic w_grant_if;

  assign w_dm_req = dm_read | dm_write;

  // On a tie the side that did not win last time goes first.
  assign w_grant_dm = w_dm_req & (~if_req | ~r_last_dm);
  assign w_grant_if = if_req & ~w_grant_dm;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = w_dm_req & ~dm_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last_dm <= 1'b0;
      r_wr      <= 1'b0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant_dm) begin
            mem_en    <= 1'b1;
            mem_we    <= dm_write;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            r_wr      <= dm_write;
            r_last_dm <= 1'b1;
            r_cnt     <= CNT_W'(MEM_LAT);
            r_state   <= DM_WAIT;
          end else if (w_grant_if) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            r_wr      <= 1'b0;
            r_last_dm <= 1'b0;
            r_cnt     <= CNT_W'(MEM_LAT);
            r_state   <= IF_WAIT;
          end
        end
        IF_WAIT, DM_WAIT: begin
          // Stores finish on the first edge after the command.
          if (r_wr) begin
            dm_valid <= 1'b1;
            r_state  <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            if (r_state == IF_WAIT) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end else begin
              dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_en_pulse: assert property (
    @(posedge clk) disable iff (!reset)
    mem_en |=> !mem_en);

  a_one_valid: assert property (
    @(posedge clk) disable iff (!reset)
    !(if_valid && dm_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: IF/DM traffic against a latency memory
// model, with command and response scoreboards.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_read, dm_write;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_valid, dm_valid;
  logic        stall_if, stall_mem;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .MEM_LAT(LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_read  (dm_read),
    .dm_write (dm_write),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gap;
    bit          mut;
    bit          drop;
  } job_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          who;
    bit          we;
    logic [31:0] data;
    int          due;
  } resp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  job_t        jobs_if[$];
  job_t        jobs_dm[$];
  resp_t       resp_q[$];
  cmd_t        glog[$];
  cmd_t        pend_c[2];
  bit          pend_v[2];
  int          pend_cyc[2];
  bit          granted[2];
  bit          busy[2];
  bit          abort = 1'b0;
  int          last_w = 0;
  int          dmv_cnt = 0;
  logic [31:0] dm_hold = '0;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] dev_mem[logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a] = d;
    dev_mem[a] = d;
  endtask

  // Memory device: command sampled at the edge after issue, read data
  // valid only in the cycle after LAT edges, junk otherwise.
  bit          pv[LAT];
  logic [31:0] pd[LAT];
  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = mem_en && !mem_we;
      pd[0] = dev_rd(mem_addr);
      if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
      mem_rdata <= pv[LAT-1] ? pd[LAT-1] : $urandom;
    end
  end

  function automatic job_t mk(input bit rd, input bit wr,
                              input logic [31:0] a,
                              input logic [31:0] d, input int gap);
    job_t j;
    j.rd = rd; j.wr = wr; j.addr = a; j.wdata = d;
    j.gap = gap; j.mut = 1'b0; j.drop = 1'b0;
    return j;
  endfunction

  function automatic int qsize(input int w);
    return (w == 0) ? jobs_if.size() : jobs_dm.size();
  endfunction

  function automatic job_t qpop(input int w);
    if (w == 0) return jobs_if.pop_front();
    return jobs_dm.pop_front();
  endfunction

  function automatic logic vld(input int w);
    return (w == 0) ? if_valid : dm_valid;
  endfunction

  task automatic apply(input int w, input bit on, input job_t j);
    if (w == 0) begin
      if_req  = on;
      if_addr = j.addr;
    end else begin
      dm_read  = on & j.rd;
      dm_write = on & j.wr;
      dm_addr  = j.addr;
      dm_wdata = j.wdata;
    end
  endtask

  task automatic drive(input int w);
    job_t j;
    int   n;
    forever begin
      if (qsize(w) != 0 && !abort) begin
        j = qpop(w);
        busy[w] = 1'b1;
        if (j.gap > 0) begin
          apply(w, 1'b0, j);
          repeat (j.gap) begin @(posedge clk); #1; end
        end
        apply(w, 1'b1, j);
        pend_c[w] = '{addr: j.addr, we: (w == 1) && j.wr,
                      wdata: j.wdata};
        pend_cyc[w] = cyc;
        pend_v[w] = 1'b1;
        granted[w] = 1'b0;
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
          if (granted[w] && (j.mut || j.drop)) begin
            if (j.mut) begin
              j.addr  = $urandom;
              j.wdata = $urandom;
            end
            apply(w, !j.drop, j);
          end
        end while (!vld(w) && n < 60 && !abort);
        if (abort) pend_v[w] = 1'b0;
        else chk(w == 0 ? "if wait" : "dm wait", vld(w), 1'b1);
        if (abort || qsize(w) == 0) apply(w, 1'b0, j);
        busy[w] = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial drive(0);
  initial drive(1);

  // Monitor: response checks, stall checks and command arbitration.
  initial begin
    bit    ev0, ev1, e0, e1;
    int    w;
    resp_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        resp_q.delete();
        last_w = 0;
        dm_hold = '0;
        granted[0] = 1'b0;
        granted[1] = 1'b0;
      end else begin
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (resp_q.size() != 0 && resp_q[0].due == cyc) begin
          if (resp_q[0].who == 0) ev0 = 1'b1;
          else ev1 = 1'b1;
        end
        chk("if_valid", if_valid, ev0);
        chk("dm_valid", dm_valid, ev1);
        if (dm_valid) dmv_cnt++;
        if (ev0) chk("if_rdata", if_rdata, resp_q[0].data);
        if (ev1) begin
          chk("dm_rdata", dm_rdata,
              resp_q[0].we ? dm_hold : resp_q[0].data);
          if (!resp_q[0].we) dm_hold = resp_q[0].data;
        end
        if (ev0 || ev1) void'(resp_q.pop_front());
        chk("stall_if", stall_if, if_req & ~ev0);
        chk("stall_mem", stall_mem, (dm_read | dm_write) & ~ev1);
        if (mem_en) begin
          glog.push_back('{addr: mem_addr, we: mem_we,
                           wdata: mem_wdata});
          e0 = pend_v[0] && pend_cyc[0] < cyc;
          e1 = pend_v[1] && pend_cyc[1] < cyc;
          if (!e0 && !e1) begin
            chk("mem_en unrequested", mem_en, 1'b0);
          end else begin
            if (e0 && e1) w = (last_w == 0) ? 1 : 0;
            else w = e1 ? 1 : 0;
            chk("mem_en overlap", resp_q.size(), 0);
            chk("mem_addr", mem_addr, pend_c[w].addr);
            chk("mem_we", mem_we, pend_c[w].we);
            if (pend_c[w].we)
              chk("mem_wdata", mem_wdata, pend_c[w].wdata);
            r.who = w;
            r.we  = pend_c[w].we;
            r.due = cyc + (r.we ? 1 : LAT + 1);
            if (r.we) begin
              ref_mem[pend_c[w].addr] = pend_c[w].wdata;
              r.data = pend_c[w].wdata;
            end else begin
              r.data = ref_rd(pend_c[w].addr);
            end
            resp_q.push_back(r);
            pend_v[w] = 1'b0;
            granted[w] = 1'b1;
            last_w = w;
          end
        end
      end
    end
  end

  task automatic check_zero(input string t);
    chk({t, "mem_en"}, mem_en, 0);
    chk({t, "mem_we"}, mem_we, 0);
    chk({t, "mem_addr"}, mem_addr, 0);
    chk({t, "mem_wdata"}, mem_wdata, 0);
    chk({t, "if_rdata"}, if_rdata, 0);
    chk({t, "dm_rdata"}, dm_rdata, 0);
    chk({t, "if_valid"}, if_valid, 0);
    chk({t, "dm_valid"}, dm_valid, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((qsize(0) != 0 || qsize(1) != 0 || busy[0] || busy[1] ||
            resp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain in time", n < 3000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g0, c0, n;
    job_t j;
    reset = 1'b0;
    if_req = 0; if_addr = 0;
    dm_read = 0; dm_write = 0; dm_addr = 0; dm_wdata = 0;

    repeat (2) begin
      @(posedge clk); #1;
      if_req   = 1'($urandom_range(0, 1));
      dm_read  = 1'($urandom_range(0, 1));
      dm_write = 1'($urandom_range(0, 1));
      if_addr  = $urandom;
      dm_addr  = $urandom;
      dm_wdata = $urandom;
      @(negedge clk);
      check_zero("rst ");
      chk("rst stall_if", stall_if, if_req);
      chk("rst stall_mem", stall_mem, dm_read | dm_write);
    end
    @(posedge clk); #1;
    if_req = 0; dm_read = 0; dm_write = 0;
    reset = 1'b1;

    preload(32'h40, 32'h002082B3);
    g0 = glog.size();
    jobs_if.push_back(mk(1'b1, 1'b0, 32'h40, 32'h0, 0));
    wait_idle();
    chk("t2 cmds", glog.size() - g0, 1);
    if (glog.size() > g0) begin
      chk("t2 addr", glog[g0].addr, 32'h40);
      chk("t2 we", glog[g0].we, 1'b0);
    end
    chk("t2 if_rdata", if_rdata, 32'h002082B3);

    g0 = glog.size();
    jobs_dm.push_back(mk(1'b0, 1'b1, 32'hD8, 32'd55, 0));
    wait_idle();
    chk("t3 cmds", glog.size() - g0, 1);
    if (glog.size() > g0) begin
      chk("t3 addr", glog[g0].addr, 32'hD8);
      chk("t3 we", glog[g0].we, 1'b1);
      chk("t3 wdata", glog[g0].wdata, 32'd55);
    end

    g0 = glog.size();
    jobs_dm.push_back(mk(1'b1, 1'b1, 32'h120, 32'hCAFEF00D, 0));
    wait_idle();
    chk("t6 cmds", glog.size() - g0, 1);
    if (glog.size() > g0) chk("t6 we", glog[g0].we, 1'b1);

    reset = 1'b0;
    g0 = glog.size();
    repeat (2) begin
      jobs_dm.push_back(mk(1'b1, 1'b0, 32'h70, 32'h0, 0));
      jobs_if.push_back(mk(1'b1, 1'b0, 32'h0, 32'h0, 0));
    end
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    wait_idle();
    chk("t4 cmds", glog.size() - g0, 4);
    if (glog.size() >= g0 + 4) begin
      chk("t4 grant0", glog[g0].addr, 32'h70);
      chk("t4 grant1", glog[g0+1].addr, 32'h0);
      chk("t4 grant2", glog[g0+2].addr, 32'h70);
      chk("t4 grant3", glog[g0+3].addr, 32'h0);
    end

    g0 = glog.size();
    jobs_dm.push_back(mk(1'b1, 1'b0, 32'h70, 32'h0, 0));
    n = 0;
    while (glog.size() == g0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5 grant", glog.size() - g0, 1);
    @(posedge clk); #2;
    abort = 1'b1;
    reset = 1'b0;
    #1;
    check_zero("t5 ");
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b0;
    c0 = dmv_cnt;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t5 no dm_valid", dmv_cnt - c0, 0);
    chk("t5 dm_rdata", dm_rdata, 0);

    for (int i = 0; i < 40; i++) begin
      j = mk(1'b1, 1'b0, 32'(4 * $urandom_range(0, 127)), 32'h0,
             $urandom_range(0, 3));
      j.mut  = ($urandom_range(0, 4) == 0);
      j.drop = !j.mut && ($urandom_range(0, 5) == 0);
      jobs_if.push_back(j);
      n = $urandom_range(0, 2);
      j = mk(n != 1, n != 0, 32'h100 + 32'(4 * $urandom_range(0, 15)),
             $urandom, $urandom_range(0, 3));
      j.mut  = ($urandom_range(0, 4) == 0);
      j.drop = !j.mut && ($urandom_range(0, 5) == 0);
      jobs_dm.push_back(j);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
